// File: rtl/ring_xfer_ctrl.sv
// ring_xfer_ctrl -- per-cluster transfer sequencer between the slide unit and
// its ring router.
//
// Accepts one inter-cluster slide/reduction command at a time. It tags the slide
// unit's outgoing beats with source/destination cluster and gates them against a
// credit budget of beats in flight. It also counts beats arriving from the ring
// for this cluster, and pulses done_o once both directions of the command are
// complete.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cluster_id_i, num_clusters_i this cluster's id, log2 of the ring size
//   cmd_valid_i / cmd_ready_o    command handshake (offset, tx beats, rx beats)
//   data_i, data_valid_i / data_ready_o   slide unit payload
//   ring_o, ring_valid_o / ring_ready_i   tagged beat to router sldu_i
//   credit_i                     one pulse per beat consumed at the destination
//   rx_valid_i, rx_ready_i       monitored router sldu_o handshake
//   done_o, err_o                one-cycle completion / error pulses
//   perf_stall_o                 stall cycle counter
//
// Optional feature macro: RING_XFER_CTRL_PERF_EN enables the stall counter;
// without it perf_stall_o is tied to zero.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid never depends on ready. Once raised, valid holds until
// the transfer, as long as the upstream source keeps its own valid high.

package ring_xfer_pkg;
  localparam int unsigned ClusterIdWidth  = 4;
  localparam int unsigned NumClusterWidth = 3;
  localparam int unsigned ElenWidth       = 64;

  typedef logic [ClusterIdWidth-1:0]  id_cluster_t;
  typedef logic [NumClusterWidth-1:0] num_cluster_t;
  typedef logic [ElenWidth-1:0]       elen_t;

  typedef struct packed {
    elen_t       data;
    id_cluster_t src_cluster;
    id_cluster_t dst_cluster;
  } remote_data_t;
endpackage

module ring_xfer_ctrl
  import ring_xfer_pkg::*;
#(
  parameter int unsigned NumCredits = 4,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  id_cluster_t         cluster_id_i,
  input  num_cluster_t        num_clusters_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  id_cluster_t         cmd_offset_i,
  input  logic [CntWidth-1:0] cmd_tx_beats_i,
  input  logic [CntWidth-1:0] cmd_rx_beats_i,
  input  elen_t               data_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  output remote_data_t        ring_o,
  output logic                ring_valid_o,
  input  logic                ring_ready_i,
  input  logic                credit_i,
  input  logic                rx_valid_i,
  input  logic                rx_ready_i,
  output logic                done_o,
  output logic                err_o,
  output logic [31:0]         perf_stall_o
);

  localparam int unsigned CredWidth = $clog2(NumCredits + 1);
  localparam int unsigned IdWidth   = ClusterIdWidth;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CntWidth-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CredWidth-1:0]  credits_q, credits_d;
  id_cluster_t           dst_q, dst_d;
  logic                  err_q, err_d;

  logic                  send_allowed;
  logic                  send;
  logic                  rx_beat;
  logic                  cmd_hs;
  logic                  credits_full;
  logic [IdWidth:0]      ring_mask;
  id_cluster_t           dst_new;

  // Outputs derived from registered state only, except the beat path which
  // passes combinationally; the router's spill registers cut that path.
  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;
  assign send_allowed = (state_q == ST_RUN) && (tx_cnt_q != '0) && (credits_q != '0);
  assign ring_valid_o = data_valid_i & send_allowed;
  assign data_ready_o = ring_ready_i & send_allowed;
  assign ring_o       = '{data: data_i, src_cluster: cluster_id_i, dst_cluster: dst_q};

  assign send         = ring_valid_o & ring_ready_i;
  assign rx_beat      = rx_valid_i & rx_ready_i;
  assign cmd_hs       = cmd_valid_i & cmd_ready_o;
  assign credits_full = (credits_q == CredWidth'(NumCredits));

  // Destination is computed one bit wider and masked to the ring size, so the
  // modular distance wraps around the ring.
  assign ring_mask = ((IdWidth + 1)'(1) << num_clusters_i) - (IdWidth + 1)'(1);
  assign dst_new   = id_cluster_t'(({1'b0, cluster_id_i} + {1'b0, cmd_offset_i}) & ring_mask);

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    credits_d = credits_q;
    dst_d     = dst_q;
    err_d     = 1'b0;

    // Credits are tracked in every state. A send and a returned credit in the
    // same cycle cancel out; a credit beyond the budget is dropped and flagged.
    if (send && !credit_i) begin
      credits_d = credits_q - CredWidth'(1);
    end else if (!send && credit_i) begin
      if (credits_full) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CredWidth'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          rx_cnt_d = cmd_rx_beats_i;
          dst_d    = dst_new;
          // A self-send would loop the whole ring: drop the transmit half.
          if (dst_new == cluster_id_i) begin
            tx_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            tx_cnt_d = cmd_tx_beats_i;
          end
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (send) begin
          tx_cnt_d = tx_cnt_q - CntWidth'(1);
        end
        if (rx_beat && (rx_cnt_q != '0)) begin
          rx_cnt_d = rx_cnt_q - CntWidth'(1);
        end
        if (tx_cnt_q == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rx_beat && (rx_cnt_q != '0)) begin
          rx_cnt_d = rx_cnt_q - CntWidth'(1);
        end
        if ((rx_cnt_q == '0) && credits_full) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      credits_q <= CredWidth'(NumCredits);
      dst_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      credits_q <= credits_d;
      dst_q     <= dst_d;
      err_q     <= err_d;
    end
  end

`ifdef RING_XFER_CTRL_PERF_EN
  // A stall is a cycle where the slide unit offers a beat the command still
  // needs, but it cannot leave for lack of credit or router backpressure.
  logic        stall_cond;
  logic [31:0] stall_q, stall_d;

  assign stall_cond = (state_q == ST_RUN) && data_valid_i && (tx_cnt_q != '0) &&
                      ((credits_q == '0) || !ring_ready_i);

  always_comb begin
    stall_d = stall_q;
    if (cmd_hs) begin
      stall_d = '0;
    end else if (stall_cond && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ring_xfer_ctrl.sv
// Directed testbench for ring_xfer_ctrl (cluster 1 in a 4-cluster ring,
// NumCredits = 4). Inputs change 1 time unit after the rising edge. Outputs
// are sampled either at that point or on the falling edge.
module tb_ring_xfer_ctrl;
  import ring_xfer_pkg::*;

  localparam int CntWidth = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  // ---------------- DUT signals ----------------
  id_cluster_t         cluster_id_i   = 4'd1;
  num_cluster_t        num_clusters_i = 3'd2;
  logic                cmd_valid_i    = 1'b0;
  logic                cmd_ready_o;
  id_cluster_t         cmd_offset_i   = '0;
  logic [CntWidth-1:0] cmd_tx_beats_i = '0;
  logic [CntWidth-1:0] cmd_rx_beats_i = '0;
  elen_t               data_i         = '0;
  logic                data_valid_i   = 1'b0;
  logic                data_ready_o;
  remote_data_t        ring_o;
  logic                ring_valid_o;
  logic                ring_ready_i   = 1'b0;
  logic                credit_i       = 1'b0;
  logic                rx_valid_i     = 1'b0;
  logic                rx_ready_i     = 1'b0;
  logic                done_o;
  logic                err_o;
  logic [31:0]         perf_stall_o;

  ring_xfer_ctrl #(.NumCredits(4), .CntWidth(CntWidth)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cluster_id_i(cluster_id_i), .num_clusters_i(num_clusters_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_offset_i(cmd_offset_i), .cmd_tx_beats_i(cmd_tx_beats_i),
    .cmd_rx_beats_i(cmd_rx_beats_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .ring_o(ring_o), .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i),
    .credit_i(credit_i), .rx_valid_i(rx_valid_i), .rx_ready_i(rx_ready_i),
    .done_o(done_o), .err_o(err_o), .perf_stall_o(perf_stall_o)
  );

  // ---------------- bench state / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sent_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          beat_idx = 0;
  int          rx_left = 0;
  bit          auto_credit = 1'b0;
  int          cred_due[$];
  logic [63:0] exp_q[$];
  id_cluster_t exp_src = 4'd1;
  id_cluster_t exp_dst = 4'd0;

`ifdef RING_XFER_CTRL_PERF_EN
  localparam int ExpStall = 7;
`else
  localparam int ExpStall = 0;
`endif

  function automatic logic [63:0] pattern(input int idx);
    return {32'hD00DBEEF, 32'(idx)};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Falling edge: observe handshakes and pulses. Edge + 1: apply the next
  // cycle's inputs (next payload, scheduled credits, rx beats).
  task automatic cycle();
    logic        fired;
    logic [63:0] exp_d;
    fired = 1'b0;
    @(negedge clk_i);
    if (ring_valid_o && ring_ready_i) begin
      fired = 1'b1;
      sent_cnt++;
      checks++;
      if (ring_o.src_cluster !== exp_src || ring_o.dst_cluster !== exp_dst) begin
        errors++;
        $display("FAIL beat_tag: got src=%0d dst=%0d, need src=%0d dst=%0d",
                 ring_o.src_cluster, ring_o.dst_cluster, exp_src, exp_dst);
      end
      checks++;
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      if (ring_o.data !== exp_d) begin
        errors++;
        $display("FAIL beat_data: got %h, need %h", ring_o.data, exp_d);
      end
      if (auto_credit) cred_due.push_back(cyc + 2);
    end
    if (done_o === 1'b1) done_cnt++;
    if (err_o === 1'b1) err_cnt++;
    @(posedge clk_i);
    #1;
    cyc++;
    cmd_valid_i = 1'b0;
    if (fired) begin
      beat_idx++;
      data_i = pattern(beat_idx);
      exp_q.push_back(data_i);
    end
    credit_i = 1'b0;
    if (cred_due.size() > 0 && cred_due[0] == cyc) begin
      credit_i = 1'b1;
      void'(cred_due.pop_front());
    end
    if (rx_left > 0) begin
      rx_valid_i = 1'b1;
      rx_ready_i = 1'b1;
      rx_left--;
    end else begin
      rx_valid_i = 1'b0;
      rx_ready_i = 1'b0;
    end
  endtask

  task automatic issue_cmd(input id_cluster_t off, input int tx, input int rx);
    cmd_valid_i    = 1'b1;
    cmd_offset_i   = off;
    cmd_tx_beats_i = CntWidth'(tx);
    cmd_rx_beats_i = CntWidth'(rx);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_issue: got %b, need 1", cmd_ready_o);
    end
    cycle();
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      if (done_cnt != start) break;
      cycle();
    end
    checks++;
    if (done_cnt != start + 1) begin
      errors++;
      $display("FAIL %s_done: got %0d done pulses, need 1", name, done_cnt - start);
    end
  endtask

  task automatic credit_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      credit_i = 1'b1;
      cycle();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({cmd_ready_o, ring_valid_o, data_ready_o, done_o, err_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/rv/dr/done/err=%b, need 10000",
               {cmd_ready_o, ring_valid_o, data_ready_o, done_o, err_o});
    end
    checks++;
    if (perf_stall_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d, need 0", perf_stall_o);
    end
    rst_i = 1'b0;
    data_valid_i = 1'b0;
    data_i = pattern(beat_idx);
    exp_q.push_back(data_i);
    cycle();
  endtask

  task automatic test_basic_xfer();
    int s0, e0;
    s0 = sent_cnt; e0 = err_cnt;
    exp_dst = 4'd0;            // (1 + 3) & 3
    auto_credit = 1'b1;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    issue_cmd(4'd3, 5, 5);
    rx_left = 5;
    wait_done(60, "basic");
    repeat (3) cycle();
    checks++;
    if (sent_cnt - s0 != 5) begin
      errors++;
      $display("FAIL basic_sent: got %0d, need 5", sent_cnt - s0);
    end
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL basic_err: got %0d err pulses, need 0", err_cnt - e0);
    end
  endtask

  task automatic test_credit_limit();
    int s0, e0;
    s0 = sent_cnt; e0 = err_cnt;
    exp_dst = 4'd2;            // (1 + 1) & 3
    auto_credit = 1'b0;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    issue_cmd(4'd1, 8, 0);
    repeat (10) cycle();
    checks++;
    if (sent_cnt - s0 != 4) begin
      errors++;
      $display("FAIL credit_limit_sent: got %0d, need 4", sent_cnt - s0);
    end
    checks++;
    if (data_ready_o !== 1'b0 || ring_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL credit_limit_stall: got dr=%b rv=%b, need 0 0", data_ready_o, ring_valid_o);
    end
    credit_pulses(1);
    repeat (5) cycle();
    checks++;
    if (sent_cnt - s0 != 5) begin
      errors++;
      $display("FAIL credit_one_more: got %0d, need 5", sent_cnt - s0);
    end
    data_valid_i = 1'b0;
    credit_pulses(4);
    data_valid_i = 1'b1;
    auto_credit = 1'b1;
    wait_done(40, "credit_limit");
    checks++;
    if (sent_cnt - s0 != 8 || err_cnt != e0) begin
      errors++;
      $display("FAIL credit_limit_total: got sent=%0d err=%0d, need 8 0",
               sent_cnt - s0, err_cnt - e0);
    end
  endtask

  task automatic test_self_send();
    int s0, e0;
    s0 = sent_cnt; e0 = err_cnt;
    exp_dst = 4'd1;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    issue_cmd(4'd4, 3, 2);     // (1 + 4) & 3 == 1 == self
    rx_left = 2;
    wait_done(20, "self_send");
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL self_send_err: got %0d err pulses, need 1", err_cnt - e0);
    end
    checks++;
    if (sent_cnt != s0) begin
      errors++;
      $display("FAIL self_send_sent: got %0d, need 0", sent_cnt - s0);
    end
  endtask

  task automatic test_credit_same_cycle();
    int s0, e0;
    s0 = sent_cnt; e0 = err_cnt;
    exp_dst = 4'd2;
    auto_credit = 1'b0;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    issue_cmd(4'd1, 12, 0);
    cycle();                   // one send: 3 credits left
    credit_pulses(5);          // five sends each paired with a credit
    repeat (8) cycle();        // exactly the 3 remaining credits drain
    checks++;
    if (sent_cnt - s0 != 9) begin
      errors++;
      $display("FAIL same_cycle_sent: got %0d, need 9", sent_cnt - s0);
    end
    checks++;
    if (data_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_stall: got data_ready=%b, need 0", data_ready_o);
    end
    data_valid_i = 1'b0;
    credit_pulses(4);          // back to full, no overflow yet
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL refill_err: got %0d err pulses, need 0", err_cnt - e0);
    end
    credit_i = 1'b1;           // one beyond the budget
    cycle();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err_high: got %b, need 1", err_o);
    end
    cycle();
    checks++;
    if (err_o !== 1'b0 || err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL overflow_err_pulse: got err=%b pulses=%0d, need 0 1", err_o, err_cnt - e0);
    end
    data_valid_i = 1'b1;
    auto_credit = 1'b1;
    wait_done(40, "same_cycle");
    checks++;
    if (sent_cnt - s0 != 12) begin
      errors++;
      $display("FAIL same_cycle_total: got %0d, need 12", sent_cnt - s0);
    end
  endtask

  task automatic test_zero_cmd();
    logic [3:0] seen;
    issue_cmd(4'd1, 0, 0);
    seen[0] = done_o;
    cycle();
    seen[1] = done_o;
    cycle();
    seen[2] = done_o;
    cycle();
    seen[3] = done_o;
    checks++;
    if (seen !== 4'b0100) begin
      errors++;
      $display("FAIL zero_cmd_done_timing: got done(c4..c1)=%b, need 0100", seen);
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_cmd_idle: got cmd_ready=%b, need 1", cmd_ready_o);
    end
  endtask

  task automatic test_reset_mid_run();
    int s0;
    exp_dst = 4'd2;
    auto_credit = 1'b0;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b1;
    issue_cmd(4'd1, 4, 0);
    checks++;
    if (ring_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_valid: got %b, need 1", ring_valid_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({cmd_ready_o, ring_valid_o, data_ready_o, done_o, err_o} !== 5'b10000 ||
        perf_stall_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_run_reset: got rdy/rv/dr/done/err=%b perf=%0d, need 10000 0",
               {cmd_ready_o, ring_valid_o, data_ready_o, done_o, err_o}, perf_stall_o);
    end
    cycle();
    rst_i = 1'b0;
    cycle();
    s0 = sent_cnt;
    issue_cmd(4'd1, 4, 0);     // full budget again after reset
    repeat (8) cycle();
    checks++;
    if (sent_cnt - s0 != 4) begin
      errors++;
      $display("FAIL post_reset_credits: got %0d sends, need 4", sent_cnt - s0);
    end
    data_valid_i = 1'b0;
    credit_pulses(4);
    wait_done(10, "post_reset");
  endtask

  task automatic test_perf_stall();
    bit held;
    held = 1'b1;
    exp_dst = 4'd2;
    auto_credit = 1'b0;
    data_valid_i = 1'b1;
    ring_ready_i = 1'b0;
    issue_cmd(4'd1, 2, 0);
    repeat (7) begin
      if (ring_valid_o !== 1'b1) held = 1'b0;
      cycle();
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL valid_held_under_backpressure: got a dropped ring_valid_o, need steady 1");
    end
    checks++;
    if (perf_stall_o !== 32'(ExpStall)) begin
      errors++;
      $display("FAIL perf_stall: got %0d, need %0d", perf_stall_o, ExpStall);
    end
    ring_ready_i = 1'b1;
    auto_credit = 1'b1;
    wait_done(30, "perf");
    checks++;
    if (perf_stall_o !== 32'(ExpStall)) begin
      errors++;
      $display("FAIL perf_stall_after: got %0d, need %0d", perf_stall_o, ExpStall);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_xfer();
    test_credit_limit();
    test_self_send();
    test_credit_same_cycle();
    test_zero_cmd();
    test_reset_mid_run();
    test_perf_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units, need finish");
    $fatal(1);
  end

endmodule
